mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single data-memory port (data_src) between two requesters in pipeline_unit: instruction fetch (IF) and load/store (LS).
- Sequences each access through a fixed-latency request/ready handshake.
- Returns read data to the owning requester only.
- LS has priority; a starvation counter guarantees IF forward progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LAT, 1, cycles from the mem_en cycle to mem_rdata valid (>=1).
- STARVE_LIMIT, 4, consecutive LS grants with IF pending before IF is forced to win (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF request, held until if_ready.
- if_addr  in  ADDR_W  IF address, stable while if_req.
- if_rdata  out  DATA_W  instruction word.
- if_ready  out  1  one-cycle completion pulse for IF.
- ls_req  in  1  LS request, held until ls_ready.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  store data.
- ls_dw  in  2  data_width encoding, passed through unchanged.
- ls_rdata  out  DATA_W  load data.
- ls_ready  out  1  one-cycle completion pulse for LS.
- mem_en  out  1  memory command strobe, exactly one cycle per access.
- mem_rw  out  1  1 = write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_dw  out  2  access width; IF always drives word.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, owner=IF, lat_cnt=0, starve_cnt=0. An in-flight access is dropped with no ready pulse; requesters re-issue.
- FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req is present, pick a winner and register owner, addr, rw, wdata and dw; go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - Only one requester active: that requester wins.
  - Both active: IF wins if starve_cnt==STARVE_LIMIT, else LS wins.
- Starvation counter:
  - LS granted while if_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - IF granted: starve_cnt=0.
  - LS granted with if_req=0: starve_cnt=0.
- ISSUE: mem_en=1 for this cycle only, command outputs from the registers.
  - Write: go to RESP.
  - Read: lat_cnt=1, go to WAIT.
- WAIT: lat_cnt increments each cycle. When lat_cnt==READ_LAT, capture mem_rdata into the owner's rdata register and go to RESP. For READ_LAT=1, WAIT lasts one cycle.
- RESP: owner's ready=1 for exactly one cycle, then go to IDLE. Requests are not sampled in RESP.
- Latency, request first seen in IDLE at cycle 0:
  - Write: mem_en at cycle 1, ready at cycle 2.
  - Read: mem_en at cycle 1, ready at cycle 2+READ_LAT.
  - Back-to-back: minimum spacing between grants is 3+READ_LAT cycles for reads, 3 for writes.
- Read data hold: if_rdata and ls_rdata keep their last captured value until the next read by the same owner. A store never changes ls_rdata.
- mem_addr, mem_rw, mem_wdata and mem_dw hold their last values outside ISSUE. mem_en=0 outside ISSUE.
- Request changes after grant: requests are ignored until IDLE, and the latched command is used. A req dropping mid-access is a protocol violation; the access still completes and ready still pulses.
- Never more than one access outstanding. if_ready and ls_ready are never high together.

Test Plan:
- Reset/idle: rst=0 then 1, no reqs for 10 cycles -> mem_en, if_ready and ls_ready stay 0; all outputs 0.
- Single IF read: READ_LAT=1, if_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en at cycle 1 with mem_addr=0x100, mem_rw=0; if_ready at cycle 3; if_rdata=0xDEADBEEF.
- LS store: ls_we=1, ls_addr=0x2004, ls_wdata=0x55AA, ls_dw=byte -> one mem_en cycle with mem_rw=1 and matching fields; ls_ready at cycle 2; ls_rdata unchanged.
- Simultaneous: if_req and ls_req both high from cycle 0 -> LS granted first; IF granted in the next IDLE.
- Starvation: if_req held, LS re-requesting every IDLE, STARVE_LIMIT=4 -> 4 LS grants, then the 5th grant goes to IF; starve_cnt returns to 0.
- Reset mid-read: READ_LAT=3, rst=0 during WAIT -> no ready pulse, mem_en=0, state IDLE; the re-issued request completes normally after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared data-memory port between instruction fetch (IF) and load/store (LS).
// LS wins ties; a saturating starvation counter forces an IF grant after STARVE_LIMIT LS wins.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LAT     = 1,
   parameter int STARVE_LIMIT = 4,
   localparam int LAT_W       = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1),
   localparam int SC_W        = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [1:0]        ls_dw,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_ready,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_dw,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        state_dbg,
   output logic [SC_W-1:0]   starve_dbg
);

   // Handshake: a requester raises req with stable command fields and holds it until its
   // ready pulses for one cycle; requests are sampled only in IDLE, so the latched command
   // is used even if req or fields change afterwards.

   localparam logic [1:0] DW_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   logic             owner_ls;
   logic [LAT_W-1:0] lat_cnt;
   logic [SC_W-1:0]  starve_cnt;
   logic             grant_if;

   always_comb begin
      grant_if = if_req && (!ls_req || (starve_cnt == SC_W'(STARVE_LIMIT)));
   end

   assign state_dbg  = state;
   assign starve_dbg = starve_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner_ls   <= 1'b0;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         if_rdata   <= '0;
         if_ready   <= 1'b0;
         ls_rdata   <= '0;
         ls_ready   <= 1'b0;
         mem_en     <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_dw     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (if_req || ls_req) begin
                  if (grant_if) begin
                     owner_ls   <= 1'b0;
                     mem_rw     <= 1'b0;
                     mem_addr   <= if_addr;
                     mem_wdata  <= '0;
                     mem_dw     <= DW_WORD;
                     starve_cnt <= '0;
                  end else begin
                     owner_ls  <= 1'b1;
                     mem_rw    <= ls_we;
                     mem_addr  <= ls_addr;
                     mem_wdata <= ls_wdata;
                     mem_dw    <= ls_dw;
                     // Counts only LS wins that made a waiting IF lose.
                     if (!if_req) begin
                        starve_cnt <= '0;
                     end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                     end
                  end
                  mem_en <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               mem_en <= 1'b0;
               if (mem_rw) begin
                  if (owner_ls) ls_ready <= 1'b1;
                  else          if_ready <= 1'b1;
                  state <= RESP;
               end else begin
                  lat_cnt <= LAT_W'(1);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == LAT_W'(READ_LAT)) begin
                  if (owner_ls) begin
                     ls_rdata <= mem_rdata;
                     ls_ready <= 1'b1;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            RESP: begin
               if_ready <= 1'b0;
               ls_ready <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with READ_LAT=1, a second with READ_LAT=3
// used for the reset-during-read scenario.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic [1:0]        ls_dw;
   logic [DATA_W-1:0] mem_rdata;

   logic [DATA_W-1:0] if_rdata, ls_rdata, mem_wdata;
   logic              if_ready, ls_ready, mem_en, mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [1:0]        mem_dw, state_dbg;
   logic [2:0]        starve_dbg;

   logic              if3_req, ls3_req;
   logic [DATA_W-1:0] if3_rdata, ls3_rdata, mem3_wdata;
   logic              if3_ready, ls3_ready, mem3_en, mem3_rw;
   logic [ADDR_W-1:0] mem3_addr;
   logic [1:0]        mem3_dw, state3_dbg;
   logic [2:0]        starve3_dbg;

   int checks = 0;
   int fails  = 0;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_dw(ls_dw),
      .ls_rdata(ls_rdata), .ls_ready(ls_ready),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_dw(mem_dw), .mem_rdata(mem_rdata),
      .state_dbg(state_dbg), .starve_dbg(starve_dbg)
   );

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3), .STARVE_LIMIT(4)) dut3 (
      .clk(clk), .rst(rst),
      .if_req(if3_req), .if_addr(if_addr), .if_rdata(if3_rdata), .if_ready(if3_ready),
      .ls_req(ls3_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_dw(ls_dw),
      .ls_rdata(ls3_rdata), .ls_ready(ls3_ready),
      .mem_en(mem3_en), .mem_rw(mem3_rw), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
      .mem_dw(mem3_dw), .mem_rdata(mem_rdata),
      .state_dbg(state3_dbg), .starve_dbg(starve3_dbg)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver/monitor: counts cycles from the IDLE grant edge, records the first command seen,
   // drops the request after its ready pulse and returns in IDLE.
   task automatic wait_access(input bit is_ls, output int en_cyc, output int rdy_cyc,
                              output int n_en, output int other_rdy,
                              output logic [ADDR_W-1:0] a, output logic rw,
                              output logic [DATA_W-1:0] wd, output logic [1:0] dw);
      en_cyc = -1; rdy_cyc = -1; n_en = 0; other_rdy = 0;
      a = '0; rw = 1'b0; wd = '0; dw = '0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_en) begin
            n_en++;
            if (en_cyc < 0) begin
               en_cyc = c; a = mem_addr; rw = mem_rw; wd = mem_wdata; dw = mem_dw;
            end
         end
         if (is_ls ? if_ready : ls_ready) other_rdy++;
         if (is_ls ? ls_ready : if_ready) begin
            rdy_cyc = c;
            break;
         end
      end
      if (is_ls) ls_req = 1'b0;
      else       if_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_en, mem_rw, if_ready, ls_ready} !== 4'b0) begin
         fails++; $display("FAIL reset_ctrl: got %b expected 0000", {mem_en, mem_rw, if_ready, ls_ready});
      end
      checks++;
      if ({mem_addr, mem_wdata, mem_dw} !== '0) begin
         fails++; $display("FAIL reset_cmd: got addr %h wdata %h dw %b expected all 0", mem_addr, mem_wdata, mem_dw);
      end
      checks++;
      if ({if_rdata, ls_rdata} !== '0) begin
         fails++; $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata, ls_rdata);
      end
      checks++;
      if ({state_dbg, starve_dbg, state3_dbg, mem3_en} !== '0) begin
         fails++; $display("FAIL reset_state: got state %0d starve %0d state3 %0d en3 %b expected 0", state_dbg, starve_dbg, state3_dbg, mem3_en);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_en, if_ready, ls_ready, mem3_en} !== 4'b0) begin
            fails++; $display("FAIL idle_quiet: cycle %0d got %b expected 0000", i, {mem_en, if_ready, ls_ready, mem3_en});
         end
      end
   endtask

   task automatic test_if_read();
      int en_c, rdy_c, n_en, oth;
      logic [ADDR_W-1:0] a; logic rw; logic [DATA_W-1:0] wd; logic [1:0] dw;
      mem_rdata = 32'hDEADBEEF;
      if_addr   = 32'h100;
      if_req    = 1'b1;
      wait_access(1'b0, en_c, rdy_c, n_en, oth, a, rw, wd, dw);
      checks++;
      if (en_c !== 1 || n_en !== 1) begin
         fails++; $display("FAIL if_read_en: got cycle %0d count %0d expected cycle 1 count 1", en_c, n_en);
      end
      checks++;
      if (a !== 32'h100 || rw !== 1'b0 || dw !== 2'b10) begin
         fails++; $display("FAIL if_read_cmd: got addr %h rw %b dw %b expected 100 0 10", a, rw, dw);
      end
      checks++;
      if (rdy_c !== 3 || oth !== 0) begin
         fails++; $display("FAIL if_read_ready: got cycle %0d ls_ready %0d expected cycle 3 ls_ready 0", rdy_c, oth);
      end
      checks++;
      if (if_rdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL if_read_data: got %h expected deadbeef", if_rdata);
      end
      checks++;
      if (if_ready !== 1'b0 || mem_en !== 1'b0 || state_dbg !== 2'd0) begin
         fails++; $display("FAIL if_read_after: got ready %b en %b state %0d expected 0 0 0", if_ready, mem_en, state_dbg);
      end
   endtask

   task automatic test_ls_load();
      int en_c, rdy_c, n_en, oth;
      logic [ADDR_W-1:0] a; logic rw; logic [DATA_W-1:0] wd; logic [1:0] dw;
      mem_rdata = 32'h12345678;
      ls_addr = 32'h300; ls_we = 1'b0; ls_dw = 2'b01; ls_wdata = 32'h0;
      ls_req = 1'b1;
      wait_access(1'b1, en_c, rdy_c, n_en, oth, a, rw, wd, dw);
      checks++;
      if (en_c !== 1 || rdy_c !== 3 || oth !== 0) begin
         fails++; $display("FAIL ls_load_timing: got en %0d ready %0d if_ready %0d expected 1 3 0", en_c, rdy_c, oth);
      end
      checks++;
      if (a !== 32'h300 || rw !== 1'b0 || dw !== 2'b01) begin
         fails++; $display("FAIL ls_load_cmd: got addr %h rw %b dw %b expected 300 0 01", a, rw, dw);
      end
      checks++;
      if (ls_rdata !== 32'h12345678 || if_rdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL ls_load_data: got ls %h if %h expected 12345678 deadbeef", ls_rdata, if_rdata);
      end
   endtask

   task automatic test_ls_store();
      int en_c, rdy_c, n_en, oth;
      logic [ADDR_W-1:0] a; logic rw; logic [DATA_W-1:0] wd; logic [1:0] dw;
      mem_rdata = 32'hFFFFFFFF;
      ls_addr = 32'h2004; ls_we = 1'b1; ls_dw = 2'b00; ls_wdata = 32'h55AA;
      ls_req = 1'b1;
      wait_access(1'b1, en_c, rdy_c, n_en, oth, a, rw, wd, dw);
      checks++;
      if (en_c !== 1 || n_en !== 1 || rdy_c !== 2) begin
         fails++; $display("FAIL ls_store_timing: got en %0d count %0d ready %0d expected 1 1 2", en_c, n_en, rdy_c);
      end
      checks++;
      if (a !== 32'h2004 || rw !== 1'b1 || wd !== 32'h55AA || dw !== 2'b00) begin
         fails++; $display("FAIL ls_store_cmd: got addr %h rw %b wdata %h dw %b expected 2004 1 55aa 00", a, rw, wd, dw);
      end
      checks++;
      if (ls_rdata !== 32'h12345678) begin
         fails++; $display("FAIL ls_store_rdata: got %h expected 12345678", ls_rdata);
      end
      checks++;
      if (mem_addr !== 32'h2004 || mem_wdata !== 32'h55AA) begin
         fails++; $display("FAIL ls_store_hold: got addr %h wdata %h expected 2004 55aa", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_simultaneous();
      int en_c, rdy_c, n_en, oth;
      logic [ADDR_W-1:0] a; logic rw; logic [DATA_W-1:0] wd; logic [1:0] dw;
      mem_rdata = 32'h0BADF00D;
      if_addr = 32'h180;
      ls_addr = 32'h500; ls_we = 1'b1; ls_wdata = 32'hA5; ls_dw = 2'b10;
      if_req = 1'b1; ls_req = 1'b1;
      wait_access(1'b1, en_c, rdy_c, n_en, oth, a, rw, wd, dw);
      checks++;
      if (a !== 32'h500 || en_c !== 1 || rdy_c !== 2 || oth !== 0) begin
         fails++; $display("FAIL simul_ls_first: got addr %h en %0d ready %0d if_ready %0d expected 500 1 2 0", a, en_c, rdy_c, oth);
      end
      checks++;
      if (starve_dbg !== 3'd1) begin
         fails++; $display("FAIL simul_starve_inc: got %0d expected 1", starve_dbg);
      end
      wait_access(1'b0, en_c, rdy_c, n_en, oth, a, rw, wd, dw);
      checks++;
      if (a !== 32'h180 || en_c !== 1 || rdy_c !== 3 || oth !== 0) begin
         fails++; $display("FAIL simul_if_next: got addr %h en %0d ready %0d ls_ready %0d expected 180 1 3 0", a, en_c, rdy_c, oth);
      end
      checks++;
      if (if_rdata !== 32'h0BADF00D || starve_dbg !== 3'd0) begin
         fails++; $display("FAIL simul_if_data: got data %h starve %0d expected 0badf00d 0", if_rdata, starve_dbg);
      end
   endtask

   task automatic test_starvation();
      logic [ADDR_W-1:0] g_addr[6];
      int g_starve[6];
      int g_cyc[6];
      int g = 0;
      bit done = 1'b0;
      logic [ADDR_W-1:0] exp_addr;
      int exp_starve;
      for (int i = 0; i < 6; i++) begin
         g_addr[i] = '0; g_starve[i] = -1; g_cyc[i] = -1;
      end
      mem_rdata = 32'h77770000;
      if_addr = 32'h1C0;
      ls_addr = 32'h600; ls_we = 1'b1; ls_wdata = 32'h1234; ls_dw = 2'b10;
      if_req = 1'b1; ls_req = 1'b1;
      for (int c = 1; c <= 80 && !done; c++) begin
         @(negedge clk);
         if (mem_en && g < 6) begin
            g_addr[g] = mem_addr; g_starve[g] = int'(starve_dbg); g_cyc[g] = c;
            g++;
         end
         if (if_ready) if_req = 1'b0;
         if (ls_ready && g == 6) begin
            ls_req = 1'b0;
            done = 1'b1;
         end
      end
      ls_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         exp_addr   = (i == 4) ? 32'h1C0 : 32'h600;
         exp_starve = (i < 4) ? i + 1 : 0;
         checks++;
         if (g_addr[i] !== exp_addr || g_starve[i] != exp_starve) begin
            fails++; $display("FAIL starve_grant%0d: got addr %h starve %0d expected %h %0d", i + 1, g_addr[i], g_starve[i], exp_addr, exp_starve);
         end
      end
      checks++;
      if (g_cyc[1] - g_cyc[0] != 3 || g_cyc[4] - g_cyc[3] != 3 || g_cyc[5] - g_cyc[4] != 4) begin
         fails++; $display("FAIL starve_spacing: got %0d %0d %0d expected 3 3 4", g_cyc[1] - g_cyc[0], g_cyc[4] - g_cyc[3], g_cyc[5] - g_cyc[4]);
      end
      checks++;
      if (if_rdata !== 32'h77770000) begin
         fails++; $display("FAIL starve_if_data: got %h expected 77770000", if_rdata);
      end
   endtask

   task automatic test_reset_mid_read();
      int en_c = -1;
      int rdy_c = -1;
      int n_rdy = 0;
      mem_rdata = 32'hCAFE0001;
      if_addr = 32'h400;
      if3_req = 1'b1;
      @(negedge clk);
      checks++;
      if (mem3_en !== 1'b1 || mem3_addr !== 32'h400) begin
         fails++; $display("FAIL rst_mid_issue: got en %b addr %h expected 1 400", mem3_en, mem3_addr);
      end
      @(negedge clk);
      checks++;
      if (state3_dbg !== 2'd2) begin
         fails++; $display("FAIL rst_mid_wait: got state %0d expected 2", state3_dbg);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (mem3_en !== 1'b0 || if3_ready !== 1'b0 || state3_dbg !== 2'd0 || if_rdata !== '0) begin
         fails++; $display("FAIL rst_mid_clear: got en %b ready %b state %0d if_rdata %h expected 0 0 0 0", mem3_en, if3_ready, state3_dbg, if_rdata);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (if3_ready) n_rdy++;
      end
      rst = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem3_en && en_c < 0) en_c = c;
         if (if3_ready) begin
            rdy_c = c;
            break;
         end
      end
      checks++;
      if (n_rdy !== 0) begin
         fails++; $display("FAIL rst_mid_no_ready: got %0d pulses expected 0", n_rdy);
      end
      checks++;
      if (en_c !== 1 || rdy_c !== 5 || if3_rdata !== 32'hCAFE0001) begin
         fails++; $display("FAIL rst_mid_reissue: got en %0d ready %0d data %h expected 1 5 cafe0001", en_c, rdy_c, if3_rdata);
      end
      if3_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_dw = 2'b00;
      mem_rdata = '0;
      if3_req = 1'b0; ls3_req = 1'b0;
      @(negedge clk);
      test_reset();
      test_if_read();
      test_ls_load();
      test_ls_store();
      test_simultaneous();
      test_starvation();
      repeat (3) @(negedge clk);
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
